// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one registered FIFO write port among REQS requesters.
// Define FIFO_ARB_PRIO_EN to make requester 0 strict priority; the others then rotate among 1..REQS-1.
module fifo_wr_arbiter #(
  parameter int REQS      = 4,
  parameter int M         = 4,
  parameter int N         = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REQS-1:0]   req,
  input  logic [REQS*M-1:0] wdata,
  output logic [REQS-1:0]   gnt,
  output logic              fifo_we,
  output logic [M-1:0]      fifo_wd,
  input  logic              fifo_re,
  input  logic              fifo_empty,
  output logic [N:0]        level,
  output logic              almost_full
);

  localparam int PW    = (REQS > 2) ? $clog2(REQS) : 1;
  localparam int DEPTH = 2 ** N;
  localparam logic [N:0] DEPTH_L = (N+1)'(DEPTH);
  localparam logic [N:0] AF_TH   = (N+1)'(DEPTH - AF_MARGIN);
`ifdef FIFO_ARB_PRIO_EN
  localparam int LO = 1;
`else
  localparam int LO = 0;
`endif
  localparam logic [PW-1:0] PTR_RST = PW'(LO);
  localparam logic [PW-1:0] PTR_TOP = PW'(REQS - 1);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N:0]    level_q, level_d;
  logic          fifo_we_q;
  logic [M-1:0]  fifo_wd_q, fifo_wd_d;
  logic          almost_full_q;

  logic            space, xfer, dec, found;
  logic [PW-1:0]   gnt_idx, cand;
  logic [REQS-1:0] gnt_c;
  logic [M-1:0]    slice [REQS];

  for (genvar gi = 0; gi < REQS; gi++) begin : g_slice
    assign slice[gi] = wdata[gi*M +: M];
  end

  // Rotating candidate: wraps back to LO so the prio build never revisits requester 0.
  function automatic logic [PW-1:0] wrap_idx(input int base, input int k);
    int i;
    i = base + k;
    if (i >= REQS) i = i - REQS + LO;
    return PW'(i);
  endfunction

  assign space = (level_q < DEPTH_L);

  always_comb begin
    gnt_c   = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (space && reset_n) begin
`ifdef FIFO_ARB_PRIO_EN
      if (req[0]) found = 1'b1;
`endif
      for (int k = 0; k < REQS - LO; k++) begin
        cand = wrap_idx(int'(rr_ptr_q), k);
        if (!found && req[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
      if (found) gnt_c[gnt_idx] = 1'b1;
    end
  end

  assign gnt  = gnt_c;
  assign xfer = |(req & gnt_c);
  assign dec  = fifo_re && !fifo_empty && (level_q != '0);

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    fifo_wd_d = fifo_wd_q;
    level_d   = level_q + (N+1)'(xfer) - (N+1)'(dec);
    if (xfer) begin
      fifo_wd_d = slice[gnt_idx];
`ifdef FIFO_ARB_PRIO_EN
      if (gnt_idx != '0)
`endif
        rr_ptr_d = (gnt_idx == PTR_TOP) ? PTR_RST : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q      <= PTR_RST;
      level_q       <= '0;
      fifo_we_q     <= 1'b0;
      fifo_wd_q     <= '0;
      almost_full_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      level_q       <= level_d;
      fifo_we_q     <= xfer;
      fifo_wd_q     <= fifo_wd_d;
      almost_full_q <= (level_d >= AF_TH);
    end
  end

  assign fifo_we     = fifo_we_q;
  assign fifo_wd     = fifo_wd_q;
  assign level       = level_q;
  assign almost_full = almost_full_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed test-plan sequences plus random traffic, scored against a FIFO-level model.
// Build with FIFO_ARB_PRIO_EN defined to exercise the strict-priority variant.
module tb_fifo_wr_arbiter;
  localparam int REQS = 4, M = 4, N = 2, AF_MARGIN = 1, DEPTH = 4;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] wdata = '0;
  logic [3:0]  gnt;
  logic        fifo_we;
  logic [3:0]  fifo_wd;
  logic        fifo_re = 1'b0, fifo_empty = 1'b1;
  logic [2:0]  level;
  logic        almost_full;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.REQS(REQS), .M(M), .N(N), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wdata(wdata), .gnt(gnt),
    .fifo_we(fifo_we), .fifo_wd(fifo_wd), .fifo_re(fifo_re), .fifo_empty(fifo_empty),
    .level(level), .almost_full(almost_full)
  );

  int         checks = 0, fails = 0;
  logic [3:0] q[$];
  logic [3:0] data [4];
  int         fifo_cnt = 0;     // words actually stored in the modelled FIFO
  bit         exp_we = 1'b0;    // word sitting in the write register
  int         last_rr = REQS - 1;
  bit         rand_data = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    int c;
    if (fifo_cnt + int'(exp_we) >= DEPTH) return -1;
`ifdef FIFO_ARB_PRIO_EN
    if (r[0]) return 0;
    for (int k = 1; k < REQS; k++) begin
      c = 1 + (last_rr - 1 + k) % (REQS - 1);
      if (r[c]) return c;
    end
`else
    for (int k = 1; k <= REQS; k++) begin
      c = (last_rr + k) % REQS;
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  // One clock cycle: drive at negedge, check grant, check registered state after the edge.
  task automatic cycle(input logic [3:0] r, input logic re);
    int p, dec, lvl;
    logic [3:0] eg;
    req        = r;
    fifo_re    = re;
    fifo_empty = (fifo_cnt == 0);
    wdata      = {data[3], data[2], data[1], data[0]};
    #1;
    p  = pick(r);
    eg = (p >= 0) ? 4'(1 << p) : 4'b0;
    chk("gnt", 32'(gnt), 32'(eg));
    dec = (re && fifo_cnt != 0) ? 1 : 0;
    if (p >= 0) begin
      q.push_back(data[p]);
`ifdef FIFO_ARB_PRIO_EN
      if (p != 0) last_rr = p;
`else
      last_rr = p;
`endif
      if (rand_data) data[p] = 4'($urandom);
    end
    @(posedge clk); #1;
    fifo_cnt = fifo_cnt + int'(exp_we) - dec;
    exp_we   = (p >= 0);
    lvl      = fifo_cnt + int'(exp_we);
    chk("fifo_we", 32'(fifo_we), 32'(exp_we));
    chk("level", 32'(level), 32'(lvl));
    chk("almost_full", 32'(almost_full), 32'(lvl >= DEPTH - AF_MARGIN));
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(posedge clk); #1;
      if (fifo_we) begin
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL wr_unexpected: got write %h required none", fifo_wd);
        end else begin
          e = q.pop_front();
          chk("fifo_wd", 32'(fifo_wd), 32'(e));
          $display("write %h (expected %h)", fifo_wd, e);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) data[i] = 4'(10 + i);
    req = 4'hF;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_we", 32'(fifo_we), 0);
    chk("rst_af", 32'(almost_full), 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    repeat (5) cycle(4'hF, 1'b0);           // rotation 0,1,2,3 then blocked
    cycle(4'b0100, 1'b1);                   // full plus read
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0010, 1'b1);                   // simultaneous write and read at level 2
    cycle(4'b0000, 1'b0);

    for (int g = 0; g < 10 && (fifo_cnt + int'(exp_we)) > 0; g++) cycle(4'b0000, 1'b1);
    cycle(4'b0100, 1'b0);                   // leaves pointer at 3
    repeat (3) cycle(4'b0101, 1'b0);        // sparse wrap

    for (int g = 0; g < 10 && (fifo_cnt + int'(exp_we)) > 2; g++) cycle(4'b0000, 1'b1);
    cycle(4'b0001, 1'b0);                   // level 3 with a write in flight
    req = 4'hF; fifo_re = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_we", 32'(fifo_we), 0);
    chk("arst_af", 32'(almost_full), 0);
    fifo_cnt = 0; exp_we = 1'b0; last_rr = REQS - 1; q.delete();
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;

    repeat (4) cycle(4'b1011, 1'b1);        // req[0] held
    repeat (4) cycle(4'b1010, 1'b1);        // req[0] dropped

    rand_data = 1'b1;
    repeat (300) cycle(4'($urandom), ($urandom_range(0, 2) != 0));
    repeat (3) cycle(4'b0000, 1'b0);
    chk("sb_empty", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of a 2**N-word × M-bit FIFO among REQS requesters. Each requester presents data with a valid/ready-style request; the arbiter grants at most one per cycle and drives the FIFO write port from a registered stage. It keeps its own occupancy count so that it never overruns the FIFO, including the write still in flight in its output register. It sits directly in front of the FIFO, and the FIFO's consumer drives the read side.

## Interface
- REQS, 4: number of requesters, at least 2.
- M, 4: data width; matches the FIFO word width.
- N, 8: log2 of the FIFO depth; DEPTH = 2**N.
- AF_MARGIN, 2: almost_full asserts when level ≥ DEPTH − AF_MARGIN.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  REQS  request per requester; bit i means wdata slice i is valid.
- wdata  in  REQS*M  requester data; requester i uses bits [i*M +: M].
- gnt  out  REQS  combinational one-hot grant; a transfer occurs on a cycle with req[i] && gnt[i].
- fifo_we  out  1  registered write enable to the FIFO.
- fifo_wd  out  M  registered write data to the FIFO.
- fifo_re  in  1  FIFO read enable, as driven by the consumer.
- fifo_empty  in  1  FIFO empty flag.
- level  out  N+1  committed entries (in the FIFO plus in flight), range 0..DEPTH.
- almost_full  out  1  registered threshold flag.

## Operation
- Space: space = (level < DEPTH). No grant is issued when space is 0. A read in the same cycle does not create space until the next cycle.
- Arbitration (combinational):
  - Search starts at rr_ptr (log2 REQS bits) and wraps modulo REQS.
  - The first i with req[i] set gets gnt[i] = 1.
  - gnt is all zeros when space is 0, when req is 0, or while reset_n is low.
- Pointer: on a transfer, rr_ptr <= (granted index + 1) mod REQS. Otherwise rr_ptr holds.
- Write stage:
  - fifo_we <= |(req & gnt).
  - fifo_wd <= wdata slice of the granted index.
  - If there is no transfer, fifo_wd holds its old value.
- Occupancy: inc = transfer this cycle; dec = fifo_re && !fifo_empty.
  - level <= level + inc − dec.
  - inc && dec together leaves level unchanged.
  - level never exceeds DEPTH and never goes below 0.
- Requester rule: hold req and wdata stable until gnt is seen. Deasserting req without a grant is allowed; the request is simply withdrawn.
- State: rr_ptr, level, fifo_we, fifo_wd, almost_full. There is no further FSM; the pointer is the arbitration state.

## Timing
- Reset (asynchronous, immediate): rr_ptr=0, level=0, fifo_we=0, fifo_wd=0, almost_full=0, gnt=0.
- Reset mid-operation: a write held in the output register is dropped. The FIFO must be reset in the same window.
- Request-to-FIFO latency: a transfer in cycle t gives fifo_we=1 in cycle t+1. The FIFO captures the word at the end of t+1.
- Throughput: one write per cycle sustained while space is 1.
- level includes the in-flight word, so fifo_full is never observed high while fifo_we=1.
- Grant in the same cycle as the request: zero-cycle ready.
- almost_full is registered from next-level, so it is valid in the same cycle as the updated level.
- Wrap: after index REQS−1 is granted, rr_ptr returns to 0.

## Configuration
- FIFO_ARB_PRIO_EN defined:
  - req[0] is strict highest priority and wins whenever asserted and space is 1; rr_ptr is not updated on its grant.
  - Requesters 1..REQS−1 rotate round-robin among themselves, with rr_ptr ranging over 1..REQS−1 and reset to 1.
- FIFO_ARB_PRIO_EN undefined: pure round-robin across all REQS, with rr_ptr reset to 0.

## Test plan
Use REQS=4, M=4, N=2 (DEPTH 4), AF_MARGIN=1, macro undefined unless stated.
- All-request rotation: req=4'b1111 held, data i=4'hA+i, fifo_re=0.
  - Grants must be 0,1,2,3 on consecutive cycles.
  - fifo_wd must be A,B,C,D one cycle later.
  - level must step 1,2,3,4, with almost_full high from level 3.
  - gnt must be 0 from the fifth cycle.
- Full plus read: start at level=4 with req[2]=1 and pulse fifo_re=1 with fifo_empty=0 for one cycle.
  - level must go to 3.
  - gnt[2] must rise on the next cycle and level must return to 4.
- Simultaneous write and read: level=2, transfer from req[1] and a read in the same cycle.
  - level must stay 2.
  - fifo_we must pulse the following cycle.
- Sparse wrap: rr_ptr=3 with req=4'b0101.
  - gnt must be 0001 first, then 0100, then 0001.
- Asynchronous reset mid-stream: assert reset_n=0 between edges while fifo_we=1 and level=3.
  - fifo_we, level, almost_full and gnt must go to 0 immediately.
  - After release, the first grant must go to requester 0.
- FIFO_ARB_PRIO_EN defined, req=4'b1011 held:
  - Grants must be 0 while req[0] stays high.
  - After req[0] drops, grants must follow 1, 3, 1, 3.
